// File: rtl/servo_track_axis.sv
// -----------------------------------------------------------------------------
// servo_track_axis
// Single-axis servo tracking controller. Once per video frame it turns the
// tracked object's coordinate error and the servo's measured position (XADC
// aux channel) into a new PWM high-time threshold. The new threshold is slew
// limited per frame and clamped to the servo's mechanical range. It holds
// inside a deadband and homes to PWM_INIT after LOST_FRAMES frames in a row
// without a detection.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active low
//   vsync_in      frame sync, asynchronous to clk
//   coord_in      object centre coordinate on this axis
//   coord_valid   coord_in is a real detection
//   MEASURED_AUX  XADC aux result, bits [15:4] significant
//   pwm_thres     servo PWM high-time threshold (registered)
//   pwm_update    one-cycle pulse when pwm_thres is rewritten
//   target_lost   high while homing (lost count saturated)
//   frame_overrun one-cycle pulse when a frame tick is dropped
// -----------------------------------------------------------------------------
module servo_track_axis #(
   parameter int COORD_W     = 11,
   parameter int CENTER      = 120,
   parameter int MAX_DIFF    = 120,
   parameter int DEADBAND    = 18,
   parameter int GAIN_NUM    = 90,
   parameter int GAIN_SHIFT  = 5,
   parameter int ADC_MUL     = 2380,
   parameter int ADC_OFFSET  = 175,
   parameter bit DIR         = 1'b0,
   parameter int PWM_W       = 15,
   parameter int PWM_MIN     = 800,
   parameter int PWM_MAX     = 2150,
   parameter int PWM_INIT    = 1500,
   parameter int MAX_STEP    = 64,
   parameter int LOST_FRAMES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync_in,
   input  logic [COORD_W-1:0] coord_in,
   input  logic               coord_valid,
   input  logic [15:0]        MEASURED_AUX,
   output logic [PWM_W-1:0]   pwm_thres,
   output logic               pwm_update,
   output logic               target_lost,
   output logic               frame_overrun
);

   localparam int ADC_SHIFT = 12;
   localparam int LOST_W    = $clog2(LOST_FRAMES + 1);
   localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_FRAMES);
   localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   state_t               state_q;
   logic                 sync1_q, sync2_q, sync3_q;
   logic [COORD_W-1:0]   coord_q;
   logic                 valid_q;
   logic [11:0]          aux_q;
   logic [LOST_W-1:0]    lost_q, lost_d;
   logic signed [31:0]   target_q, target_d;
   logic [PWM_W-1:0]     pwm_q, pwm_d;
   logic                 update_q, lost_flag_q, overrun_q;
   logic                 tick;

   logic signed [31:0]   coord_ext, aux_ext, cur;
   logic signed [31:0]   diff, abs_diff, mag, pos, corr;
   logic signed [31:0]   delta, delta_c, stepped, clamped;
   logic                 frame_ok, add_corr;

   // Low nibble of the XADC word carries no information.
   logic unused_aux_lsbs;
   assign unused_aux_lsbs = ^MEASURED_AUX[3:0];

   assign tick      = sync2_q & ~sync3_q;
   assign coord_ext = $signed(32'(coord_q));
   assign aux_ext   = $signed(32'(aux_q));
   assign cur       = $signed(32'(pwm_q));

   // Bring vsync into the clk domain and keep one delayed copy for edge detect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= vsync_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Frame target and lost-count bookkeeping from the captured inputs.
   always_comb begin
      frame_ok = valid_q && (coord_ext != 32'sd0) && (coord_ext < 2 * CENTER);
      diff     = coord_ext - CENTER;
      if (diff < 32'sd0) begin
         abs_diff = -diff;
      end else begin
         abs_diff = diff;
      end
      if (abs_diff > MAX_DIFF) begin
         mag = MAX_DIFF;
      end else begin
         mag = abs_diff;
      end
      pos      = ((aux_ext * ADC_MUL) >>> ADC_SHIFT) + ADC_OFFSET;
      corr     = (mag * GAIN_NUM) >>> GAIN_SHIFT;
      // DIR flips which side of centre pushes the threshold upward.
      add_corr = (coord_ext < CENTER) ^ DIR;
      target_d = cur;
      lost_d   = lost_q;
      if (frame_ok) begin
         lost_d = '0;
         if (mag <= DEADBAND) begin
            target_d = cur;
         end else if (add_corr) begin
            target_d = pos + corr;
         end else begin
            target_d = pos - corr;
         end
      end else begin
         if (lost_q < LOST_MAX) begin
            lost_d = lost_q + LOST_ONE;
         end else begin
            lost_d = lost_q;
         end
         if (lost_d == LOST_MAX) begin
            target_d = PWM_INIT;
         end else begin
            target_d = cur;
         end
      end
   end

   // Slew-limit toward the target, then clamp to the servo range.
   always_comb begin
      delta = target_q - cur;
      if (delta > MAX_STEP) begin
         delta_c = MAX_STEP;
      end else if (delta < -MAX_STEP) begin
         delta_c = -MAX_STEP;
      end else begin
         delta_c = delta;
      end
      stepped = cur + delta_c;
      if (stepped > PWM_MAX) begin
         clamped = PWM_MAX;
      end else if (stepped < PWM_MIN) begin
         clamped = PWM_MIN;
      end else begin
         clamped = stepped;
      end
      pwm_d = PWM_W'(clamped);
   end

   // Frame FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         coord_q     <= '0;
         valid_q     <= 1'b0;
         aux_q       <= '0;
         lost_q      <= '0;
         target_q    <= 32'sd0;
         pwm_q       <= PWM_W'(PWM_INIT);
         update_q    <= 1'b0;
         lost_flag_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         update_q  <= 1'b0;
         overrun_q <= tick && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  coord_q <= coord_in;
                  valid_q <= coord_valid;
                  aux_q   <= MEASURED_AUX[15:4];
                  state_q <= ST_CALC;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CALC: begin
               target_q <= target_d;
               lost_q   <= lost_d;
               state_q  <= ST_APPLY;
            end
            ST_APPLY: begin
               pwm_q       <= pwm_d;
               update_q    <= 1'b1;
               lost_flag_q <= (lost_q == LOST_MAX);
               state_q     <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign pwm_thres     = pwm_q;
   assign pwm_update    = update_q;
   assign target_lost   = lost_flag_q;
   assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_servo_track_axis.sv
// -----------------------------------------------------------------------------
// tb_servo_track_axis
// Two instances share stimulus: A uses default parameters, B uses DIR=1 and a
// slew limit wide enough to expose range clamping. Stimulus pushes expected
// results into per-instance queues; monitors pop on every pwm_update.
// -----------------------------------------------------------------------------
module tb_servo_track_axis;

   typedef struct {
      int pwm;
      int lost;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vsync_in = 1'b0;
   logic [10:0] coord_in = 11'd0;
   logic        coord_valid = 1'b0;
   logic [15:0] MEASURED_AUX = 16'd0;

   logic [14:0] pwm_a, pwm_b;
   logic        upd_a, upd_b, lost_a, lost_b, ovr_a, ovr_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   int   ovr_cnt_a = 0;
   int   ovr_cnt_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   m_pwm[2];
   int   m_lost[2];

   servo_track_axis u_dut_a (
      .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .coord_in(coord_in),
      .coord_valid(coord_valid), .MEASURED_AUX(MEASURED_AUX),
      .pwm_thres(pwm_a), .pwm_update(upd_a), .target_lost(lost_a),
      .frame_overrun(ovr_a)
   );

   servo_track_axis #(.DIR(1'b1), .MAX_STEP(4096)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .coord_in(coord_in),
      .coord_valid(coord_valid), .MEASURED_AUX(MEASURED_AUX),
      .pwm_thres(pwm_b), .pwm_update(upd_b), .target_lost(lost_b),
      .frame_overrun(ovr_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model of one frame for instance d (0: DIR=0 step 64, 1: DIR=1 step 4096).
   function automatic void model_frame(input int d, input int coord, input bit valid,
                                       input int aux, output int nv, output int lf);
      int step, target, cur, err, mag, pos, corr, dlt;
      bit up;
      step = (d == 0) ? 64 : 4096;
      cur  = m_pwm[d];
      if (valid && coord > 0 && coord < 240) begin
         err  = coord - 120;
         mag  = (err < 0) ? -err : err;
         if (mag > 120) mag = 120;
         pos  = (aux / 16) * 2380 / 4096 + 175;
         corr = mag * 90 / 32;
         up   = (coord < 120) != (d == 1);
         if (mag <= 18) target = cur;
         else target = up ? pos + corr : pos - corr;
         m_lost[d] = 0;
      end else begin
         if (m_lost[d] < 4) m_lost[d]++;
         target = (m_lost[d] == 4) ? 1500 : cur;
      end
      dlt = target - cur;
      if (dlt > step) dlt = step;
      if (dlt < -step) dlt = -step;
      nv = cur + dlt;
      if (nv > 2150) nv = 2150;
      if (nv < 800) nv = 800;
      m_pwm[d] = nv;
      lf = (m_lost[d] == 4) ? 1 : 0;
   endfunction

   task automatic push_expect(input int coord, input bit valid, input int aux);
      exp_t e;
      int nv, lf;
      model_frame(0, coord, valid, aux, nv, lf);
      e.pwm = nv; e.lost = lf; e.cyc = cyc + 5;
      q_a.push_back(e);
      model_frame(1, coord, valid, aux, nv, lf);
      e.pwm = nv; e.lost = lf; e.cyc = cyc + 5;
      q_b.push_back(e);
   endtask

   task automatic set_inputs(input int coord, input bit valid, input int aux);
      logic [31:0] c, a;
      c = coord; a = aux;
      coord_in     = c[10:0];
      coord_valid  = valid;
      MEASURED_AUX = a[15:0];
   endtask

   // Scramble inputs between ticks; they must have no effect.
   task automatic scramble();
      coord_in     = 11'($urandom_range(0, 2047));
      coord_valid  = 1'($urandom_range(0, 1));
      MEASURED_AUX = 16'($urandom_range(0, 65535));
   endtask

   task automatic do_frame(input int coord, input bit valid, input int aux);
      set_inputs(coord, valid, aux);
      push_expect(coord, valid, aux);
      vsync_in = 1'b1;
      @(posedge clk); #1;
      vsync_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      scramble();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_pwm[d]  = 1500;
         m_lost[d] = 0;
      end
   endtask

   // Monitor for instance A.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && upd_a !== 1'b0) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_update", 32'(upd_a), 32'd0);
         end else begin
            e = q_a.pop_front();
            check("a_pwm", 32'(pwm_a), e.pwm);
            check("a_lost", 32'(lost_a), e.lost);
            check("a_latency", cyc, e.cyc);
         end
      end
      if (mon_en && ovr_a === 1'b1) ovr_cnt_a++;
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && upd_b !== 1'b0) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_update", 32'(upd_b), 32'd0);
         end else begin
            e = q_b.pop_front();
            check("b_pwm", 32'(pwm_b), e.pwm);
            check("b_lost", 32'(lost_b), e.lost);
            check("b_latency", cyc, e.cyc);
         end
      end
      if (mon_en && ovr_b === 1'b1) ovr_cnt_b++;
   end

   initial begin
      int oa, ob;
      int coord, aux;
      bit valid;

      repeat (3) @(posedge clk);
      #1;
      do_reset();
      mon_en = 1'b1;
      check("rst_pwm_a", 32'(pwm_a), 32'd1500);
      check("rst_pwm_b", 32'(pwm_b), 32'd1500);
      check("rst_upd_a", 32'(upd_a), 32'd0);
      check("rst_lost_a", 32'(lost_a), 32'd0);
      check("rst_ovr_a", 32'(ovr_a), 32'd0);
      check("rst_lost_b", 32'(lost_b), 32'd0);

      // Basic tracking, mid-scale ADC.
      do_frame(60, 1'b1, 32'h8000);
      do_reset();
      repeat (3) do_frame(200, 1'b1, 32'h8000);
      do_reset();
      do_frame(130, 1'b1, 32'h8000);
      do_frame(138, 1'b1, 32'h8000);
      do_frame(102, 1'b1, 32'h8000);
      do_frame(139, 1'b1, 32'h8000);
      do_reset();
      do_frame(60, 1'b1, 32'h8000);

      // Range clamping and coordinate boundaries.
      do_reset();
      do_frame(1, 1'b1, 32'hFFF0);
      do_frame(239, 1'b1, 32'h0000);
      do_frame(0, 1'b1, 32'h8000);
      do_frame(240, 1'b1, 32'h8000);
      do_frame(400, 1'b1, 32'h8000);

      // Drive high, then lose the target long enough to home, then recover.
      do_reset();
      repeat (12) do_frame(1, 1'b1, 32'hFFF0);
      repeat (6) do_frame(60, 1'b0, 32'h8000);
      do_frame(60, 1'b1, 32'h8000);

      // Two ticks two clocks apart: one update, one overrun.
      oa = ovr_cnt_a; ob = ovr_cnt_b;
      set_inputs(200, 1'b1, 32'h8000);
      push_expect(200, 1'b1, 32'h8000);
      vsync_in = 1'b1; @(posedge clk); #1;
      vsync_in = 1'b0; @(posedge clk); #1;
      vsync_in = 1'b1; @(posedge clk); #1;
      vsync_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("overrun_a", ovr_cnt_a - oa, 32'd1);
      check("overrun_b", ovr_cnt_b - ob, 32'd1);

      // Reset while in CALC aborts the frame without an update.
      do_frame(60, 1'b1, 32'h8000);
      set_inputs(60, 1'b1, 32'h8000);
      vsync_in = 1'b1; @(posedge clk); #1;
      vsync_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("abort_pwm_a", 32'(pwm_a), 32'd1500);
      check("abort_pwm_b", 32'(pwm_b), 32'd1500);
      check("abort_lost_a", 32'(lost_a), 32'd0);
      repeat (6) @(posedge clk);
      #1;

      // Randomised frames.
      for (int i = 0; i < 150; i++) begin
         coord = $urandom_range(0, 300);
         valid = ($urandom_range(0, 3) != 0);
         aux   = $urandom_range(0, 65535);
         do_frame(coord, valid, aux);
      end

      repeat (10) @(posedge clk);
      #1;
      check("drain_a", q_a.size(), 32'd0);
      check("drain_b", q_b.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
